// File: rtl/pong_game_ctrl.sv
// Game-select / reset sequencer for a ball-and-paddle game chip: debounced buttons,
// frame-aligned game changes and manual serve. Optional attract mode: PONG_ATTRACT_MODE_EN.
module pong_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_CYCLES    = 1024,
  parameter int SERVE_CYCLES    = 4096,
  parameter int ATTRACT_FRAMES  = 1800
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_serve,
  input  logic       sw_angle,
  input  logic       sw_speed,
  input  logic       sw_batsize,
  output logic       chip_reset_n,
  output logic [5:0] game_sel_n,
  output logic       man_serve,
  output logic       ball_angle,
  output logic       ball_speed,
  output logic       bat_size,
  output logic       busy,
  output logic       attract
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SERVE_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

  localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [SERVE_W-1:0] SERVE_MAX = SERVE_W'(SERVE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;

  logic [5:0] raw;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic       vsync_d;
  logic [4:0] sync_d;
  logic [4:0] db_level;
  logic [1:0] btn_d;
  logic [DB_W-1:0] db_cnt [5];

  logic frame_tick;
  logic next_press;
  logic serve_press;
  logic advance;

  logic [2:0]         game;
  logic [2:0]         next_game;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SERVE_W-1:0] serve_cnt;

  // Bit 0 is vsync; bits 1..5 are the debounced channels (next, serve, angle, speed, batsize).
  assign raw = {sw_batsize, sw_speed, sw_angle, btn_serve, btn_next, vsync};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      vsync_d  <= 1'b0;
      sync_d   <= '0;
      db_level <= '0;
      btn_d    <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      vsync_d <= sync2[0];
      sync_d  <= sync2[5:1];
      btn_d   <= db_level[1:0];
      for (int i = 0; i < 5; i++) begin
        if (sync2[i+1] != sync_d[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_level[i] <= sync_d[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign frame_tick  = sync2[0] & ~vsync_d;
  assign next_press  = db_level[0] & ~btn_d[0];
  assign serve_press = db_level[1] & ~btn_d[1];

`ifdef PONG_ATTRACT_MODE_EN
  localparam int IDLE_W = (ATTRACT_FRAMES > 1) ? $clog2(ATTRACT_FRAMES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(ATTRACT_FRAMES - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              any_press;
  logic              attract_fire;

  assign any_press    = next_press | serve_press;
  assign attract_fire = (state == RUN) && frame_tick && !any_press && (idle_cnt == IDLE_MAX);
  assign advance      = next_press | attract_fire;

  // Idle frames are only counted while a game is running; any press ends attract.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      attract  <= 1'b0;
    end else if (any_press) begin
      idle_cnt <= '0;
      attract  <= 1'b0;
    end else if (attract_fire) begin
      idle_cnt <= '0;
      attract  <= 1'b1;
    end else if (state == RUN && frame_tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign advance = next_press;
  assign attract = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HOLD;
      game         <= 3'd0;
      next_game    <= 3'd0;
      game_sel_n   <= 6'b111110;
      chip_reset_n <= 1'b0;
      busy         <= 1'b1;
      hold_cnt     <= '0;
      man_serve    <= 1'b0;
      serve_cnt    <= '0;
      ball_angle   <= 1'b0;
      ball_speed   <= 1'b0;
      bat_size     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (frame_tick) {bat_size, ball_speed, ball_angle} <= db_level[4:2];
          // A game change outranks a serve and cuts any pulse in progress short.
          if (advance) begin
            next_game <= (game == 3'd5) ? 3'd0 : game + 3'd1;
            state     <= PEND;
            busy      <= 1'b1;
            man_serve <= 1'b0;
            serve_cnt <= '0;
          end else if (man_serve) begin
            if (serve_cnt == SERVE_MAX) begin
              man_serve <= 1'b0;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end else if (serve_press) begin
            man_serve <= 1'b1;
            serve_cnt <= '0;
          end
        end
        PEND: begin
          if (frame_tick) begin
            game         <= next_game;
            game_sel_n   <= ~(6'b000001 << next_game);
            chip_reset_n <= 1'b0;
            hold_cnt     <= '0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          {bat_size, ball_speed, ball_angle} <= db_level[4:2];
          if (hold_cnt == HOLD_MAX) begin
            chip_reset_n <= 1'b1;
            busy         <= 1'b0;
            state        <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          chip_reset_n <= 1'b0;
          busy         <= 1'b1;
          hold_cnt     <= '0;
          state        <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with small timing parameters.
// Build with +define+PONG_ATTRACT_MODE_EN to exercise attract mode.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_serve = 1'b0;
  logic       sw_angle = 1'b0;
  logic       sw_speed = 1'b0;
  logic       sw_batsize = 1'b0;
  logic       chip_reset_n;
  logic [5:0] game_sel_n;
  logic       man_serve;
  logic       ball_angle;
  logic       ball_speed;
  logic       bat_size;
  logic       busy;
  logic       attract;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES(8),
    .SERVE_CYCLES(3),
    .ATTRACT_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vsync(vsync),
    .btn_next(btn_next),
    .btn_serve(btn_serve),
    .sw_angle(sw_angle),
    .sw_speed(sw_speed),
    .sw_batsize(sw_batsize),
    .chip_reset_n(chip_reset_n),
    .game_sel_n(game_sel_n),
    .man_serve(man_serve),
    .ball_angle(ball_angle),
    .ball_speed(ball_speed),
    .bat_size(bat_size),
    .busy(busy),
    .attract(attract)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(10);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    step(4);
    vsync = 1'b0;
    step(4);
  endtask

  task automatic press_next(input int n);
    btn_next = 1'b1;
    step(n);
    btn_next = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    int  edges;
    logic prev_busy;
    reset_n  = 1'b0;
    sw_angle = 1'b1;
    step(3);
    n_checks++;
    if (game_sel_n !== 6'b111110) begin n_fail++; $display("[TB] FAIL reset_game_sel: got %b expected 111110", game_sel_n); end
    n_checks++;
    if (chip_reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_chip_reset_n: got %b expected 0", chip_reset_n); end
    n_checks++;
    if ({man_serve, ball_angle, ball_speed, bat_size, attract} !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %b expected 00000", {man_serve, ball_angle, ball_speed, bat_size, attract});
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end

    reset_n   = 1'b1;
    edges     = 0;
    prev_busy = busy;
    for (int i = 0; i < 30; i++) begin
      if (chip_reset_n === 1'b1) break;
      prev_busy = busy;
      step(1);
      edges++;
    end
    n_checks++;
    if (edges !== 8) begin n_fail++; $display("[TB] FAIL release_low_edges: got %0d expected 8", edges); end
    n_checks++;
    if ({prev_busy, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL busy_falls_with_reset: got %b expected 10", {prev_busy, busy}); end
    n_checks++;
    if (ball_angle !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_loads_options: got %b expected 1", ball_angle); end
    sw_angle = 1'b0;

    // Reset while a change is pending: the change is abandoned.
    do_reset();
    press_next(12);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_before_reset: got %b expected 1", busy); end
    do_reset();
    pulse_vsync();
    step(10);
    n_checks++;
    if ({game_sel_n, busy} !== {6'b111110, 1'b0}) begin
      n_fail++; $display("[TB] FAIL reset_abandons_change: got %b/%b expected 111110/0", game_sel_n, busy);
    end
  endtask

  task automatic test_next_wrap();
    logic [5:0] exp_tab [6];
    int edges;
    exp_tab = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    do_reset();
    press_next(12);
    n_checks++;
    if ({busy, game_sel_n} !== {1'b1, 6'b111110}) begin
      n_fail++; $display("[TB] FAIL pend_no_change: got %b/%b expected 1/111110", busy, game_sel_n);
    end
    vsync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (game_sel_n !== 6'b111110) break;
      step(1);
    end
    n_checks++;
    if ({game_sel_n, chip_reset_n} !== {6'b111101, 1'b0}) begin
      n_fail++; $display("[TB] FAIL first_change: got %b/%b expected 111101/0", game_sel_n, chip_reset_n);
    end
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      if (chip_reset_n === 1'b1) break;
      step(1);
      edges++;
    end
    n_checks++;
    if (edges !== 8) begin n_fail++; $display("[TB] FAIL change_low_edges: got %0d expected 8", edges); end
    vsync = 1'b0;
    step(4);
    for (int k = 2; k <= 6; k++) begin
      press_next(12);
      pulse_vsync();
      step(10);
      n_checks++;
      if ({game_sel_n, busy} !== {exp_tab[k % 6], 1'b0}) begin
        n_fail++; $display("[TB] FAIL wrap_press_%0d: got %b/%b expected %b/0", k, game_sel_n, busy, exp_tab[k % 6]);
      end
    end
  endtask

  task automatic test_glitch_and_drop();
    do_reset();
    repeat (4) begin
      btn_next = 1'b1;
      step(2);
      btn_next = 1'b0;
      step(3);
    end
    step(10);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
    pulse_vsync();
    step(4);
    n_checks++;
    if (game_sel_n !== 6'b111110) begin n_fail++; $display("[TB] FAIL glitch_game: got %b expected 111110", game_sel_n); end

    press_next(12);
    btn_next = 1'b1;
    vsync    = 1'b1;
    step(4);
    vsync = 1'b0;
    step(20);
    btn_next = 1'b0;
    step(10);
    n_checks++;
    if ({game_sel_n, busy} !== {6'b111101, 1'b0}) begin
      n_fail++; $display("[TB] FAIL hold_press_dropped: got %b/%b expected 111101/0", game_sel_n, busy);
    end
  endtask

  task automatic test_serve();
    int highs;
    int first;
    do_reset();
    highs = 0;
    first = 0;
    btn_serve = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      if (man_serve === 1'b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
    n_checks++;
    if (highs !== 3) begin n_fail++; $display("[TB] FAIL serve_width: got %0d expected 3", highs); end
    n_checks++;
    if (first !== 8) begin n_fail++; $display("[TB] FAIL serve_start: got %0d expected 8", first); end
    btn_serve = 1'b0;
    step(10);

    // Next arriving two cycles behind serve cuts the pulse after two cycles.
    highs = 0;
    btn_serve = 1'b1;
    step(2);
    btn_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (man_serve === 1'b1) highs++;
    end
    n_checks++;
    if ({highs, busy} !== {32'd2, 1'b1}) begin
      n_fail++; $display("[TB] FAIL serve_cut_by_next: got %0d/%b expected 2/1", highs, busy);
    end
    btn_serve = 1'b0;
    btn_next  = 1'b0;
    step(10);
    pulse_vsync();
    step(10);
    n_checks++;
    if (game_sel_n !== 6'b111101) begin n_fail++; $display("[TB] FAIL serve_cut_game: got %b expected 111101", game_sel_n); end

    highs = 0;
    btn_serve = 1'b1;
    btn_next  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (man_serve === 1'b1) highs++;
    end
    n_checks++;
    if ({highs, busy} !== {32'd0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL simultaneous_next_serve: got %0d/%b expected 0/1", highs, busy);
    end
    btn_serve = 1'b0;
    btn_next  = 1'b0;
    step(10);
    pulse_vsync();
    step(10);
    n_checks++;
    if (game_sel_n !== 6'b111011) begin n_fail++; $display("[TB] FAIL simultaneous_game: got %b expected 111011", game_sel_n); end
  endtask

  task automatic test_options();
    int edges;
    do_reset();
    sw_speed = 1'b1;
    step(15);
    n_checks++;
    if (ball_speed !== 1'b0) begin n_fail++; $display("[TB] FAIL speed_before_tick: got %b expected 0", ball_speed); end
    vsync = 1'b1;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      if (ball_speed === 1'b1) break;
      step(1);
      edges++;
    end
    n_checks++;
    if ({ball_speed, edges} !== {1'b1, 32'd3}) begin
      n_fail++; $display("[TB] FAIL speed_at_tick: got %b after %0d edges expected 1 after 3", ball_speed, edges);
    end
    vsync = 1'b0;
    step(4);
    n_checks++;
    if ({ball_angle, bat_size} !== 2'b00) begin n_fail++; $display("[TB] FAIL other_options: got %b expected 00", {ball_angle, bat_size}); end
    sw_batsize = 1'b1;
    step(15);
    n_checks++;
    if (bat_size !== 1'b0) begin n_fail++; $display("[TB] FAIL batsize_no_tick: got %b expected 0", bat_size); end
    sw_batsize = 1'b0;
    sw_speed   = 1'b0;
    step(10);
  endtask

  task automatic test_attract();
    do_reset();
    pulse_vsync();
    pulse_vsync();
    step(2);
`ifdef PONG_ATTRACT_MODE_EN
    n_checks++;
    if ({attract, busy, game_sel_n} !== {1'b1, 1'b1, 6'b111110}) begin
      n_fail++; $display("[TB] FAIL attract_fire: got %b/%b/%b expected 1/1/111110", attract, busy, game_sel_n);
    end
    pulse_vsync();
    step(10);
    n_checks++;
    if ({attract, busy, game_sel_n} !== {1'b1, 1'b0, 6'b111101}) begin
      n_fail++; $display("[TB] FAIL attract_advance: got %b/%b/%b expected 1/0/111101", attract, busy, game_sel_n);
    end
    btn_serve = 1'b1;
    step(12);
    btn_serve = 1'b0;
    n_checks++;
    if (attract !== 1'b0) begin n_fail++; $display("[TB] FAIL attract_clear: got %b expected 0", attract); end
    step(10);
`else
    n_checks++;
    if ({attract, busy, game_sel_n} !== {1'b0, 1'b0, 6'b111110}) begin
      n_fail++; $display("[TB] FAIL no_attract: got %b/%b/%b expected 0/0/111110", attract, busy, game_sel_n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_next_wrap();
    test_glitch_and_drop();
    test_serve();
    test_options();
    test_attract();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
